// File: rtl/cache_pkg.sv
// Shared constants for the write-back direct-mapped cache controller:
// geometry defaults, FSM state encodings and a saturating counter helper.
package cache_pkg;

   localparam int ADDR_W      = 10;
   localparam int DATA_W      = 32;
   localparam int INDEX_W     = 2;
   localparam int OFFSET_W    = 2;
   localparam int BLOCK_WORDS = 1 << OFFSET_W;
   localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_COMPARE   = 2'd1;
   localparam logic [1:0] ST_WRITEBACK = 2'd2;
   localparam logic [1:0] ST_ALLOCATE  = 2'd3;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] satInc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/cache_ctrl_wb_if.sv
// CPU load/store port and main-memory beat port of the cache controller.
// The cache itself uses the slave modport; the CPU/memory side uses master.
interface cache_ctrl_wb_if #(
   parameter int ADDR_W = cache_pkg::ADDR_W,
   parameter int DATA_W = cache_pkg::DATA_W
);

   logic              cpuReq;
   logic              isRead;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writeData;
   logic              cpuReady;
   logic [DATA_W-1:0] readData;
   logic              isHit;

   logic              memReq;
   logic              memWrite;
   logic [ADDR_W-1:0] memAddress;
   logic [DATA_W-1:0] memWriteData;
   logic [DATA_W-1:0] memReadData;
   logic              memAck;

   modport master (
      output cpuReq, isRead, address, writeData, memReadData, memAck,
      input  cpuReady, readData, isHit, memReq, memWrite, memAddress, memWriteData
   );

   modport slave (
      input  cpuReq, isRead, address, writeData, memReadData, memAck,
      output cpuReady, readData, isHit, memReq, memWrite, memAddress, memWriteData
   );

endinterface

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays of the direct-mapped cache. Reads are
// combinational for the selected line; only valid/dirty are reset.
module cache_line_store #(
   parameter int INDEX_W  = cache_pkg::INDEX_W,
   parameter int OFFSET_W = cache_pkg::OFFSET_W,
   parameter int TAG_W    = cache_pkg::TAG_W,
   parameter int DATA_W   = cache_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rstN,
   input  logic [INDEX_W-1:0]  index,
   input  logic [OFFSET_W-1:0] rdOffset,
   output logic                lineValid,
   output logic                lineDirty,
   output logic [TAG_W-1:0]    lineTag,
   output logic [DATA_W-1:0]   lineWord,
   input  logic                wordWe,
   input  logic [OFFSET_W-1:0] wrOffset,
   input  logic [DATA_W-1:0]   wrData,
   input  logic                tagWe,
   input  logic [TAG_W-1:0]    wrTag,
   input  logic                dirtySet,
   input  logic                dirtyClr
);

   localparam int Lines = 1 << INDEX_W;
   localparam int Words = 1 << OFFSET_W;

   logic [Lines-1:0]  validBits;
   logic [Lines-1:0]  dirtyBits;
   logic [TAG_W-1:0]  tagMem  [Lines];
   logic [DATA_W-1:0] dataMem [Lines][Words];

   assign lineValid = validBits[index];
   assign lineDirty = dirtyBits[index];
   assign lineTag   = tagMem[index];
   assign lineWord  = dataMem[index][rdOffset];

   // Payload storage carries no reset; a line is only trusted once valid.
   always_ff @(posedge clk) begin
      if (wordWe) begin
         dataMem[index][wrOffset] <= wrData;
      end
      if (tagWe) begin
         tagMem[index] <= wrTag;
      end
   end

   // Installing a new tag marks the line valid and clean in the same edge.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         validBits <= '0;
         dirtyBits <= '0;
      end else begin
         if (tagWe) begin
            validBits[index] <= 1'b1;
            dirtyBits[index] <= 1'b0;
         end
         if (dirtySet) begin
            dirtyBits[index] <= 1'b1;
         end else if (dirtyClr) begin
            dirtyBits[index] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cache_ctrl_wb.sv
// Write-back, write-allocate direct-mapped cache controller with victim
// write-back and refill bursts. Define CACHE_STATS_EN for hit/miss/wb counters.
module cache_ctrl_wb #(
   parameter int ADDR_W   = cache_pkg::ADDR_W,
   parameter int DATA_W   = cache_pkg::DATA_W,
   parameter int INDEX_W  = cache_pkg::INDEX_W,
   parameter int OFFSET_W = cache_pkg::OFFSET_W
) (
   input  logic          clk,
   input  logic          rstN,
   cache_ctrl_wb_if.slave bus
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]   hitCount,
   output logic [15:0]   missCount,
   output logic [15:0]   wbCount
`endif
);

   import cache_pkg::*;

   localparam int TagW = ADDR_W - INDEX_W - OFFSET_W;
   localparam logic [OFFSET_W-1:0] LastBeat = '1;

   logic [1:0]          state;
   logic [OFFSET_W-1:0] beatCnt;
   logic                missFlag;
   logic                reqIsRead;
   logic [ADDR_W-1:0]   reqAddr;
   logic [DATA_W-1:0]   reqData;

   logic [TagW-1:0]     reqTag;
   logic [INDEX_W-1:0]  reqIndex;
   logic [OFFSET_W-1:0] reqOffset;

   logic                lineValid;
   logic                lineDirty;
   logic [TagW-1:0]     lineTag;
   logic [DATA_W-1:0]   lineWord;
   logic [OFFSET_W-1:0] rdOffset;
   logic                hit;
   logic                beatDone;

   logic                wordWe;
   logic [OFFSET_W-1:0] wrOffset;
   logic [DATA_W-1:0]   wrData;
   logic                tagWe;
   logic                dirtySet;
   logic                dirtyClr;

   assign reqTag    = reqAddr[ADDR_W-1 -: TagW];
   assign reqIndex  = reqAddr[OFFSET_W +: INDEX_W];
   assign reqOffset = reqAddr[OFFSET_W-1:0];
   assign rdOffset  = (state == ST_COMPARE) ? reqOffset : beatCnt;
   assign hit       = lineValid && (lineTag == reqTag);
   assign beatDone  = bus.memReq && bus.memAck;

   cache_line_store #(
      .INDEX_W  (INDEX_W),
      .OFFSET_W (OFFSET_W),
      .TAG_W    (TagW),
      .DATA_W   (DATA_W)
   ) lineStore (
      .clk       (clk),
      .rstN      (rstN),
      .index     (reqIndex),
      .rdOffset  (rdOffset),
      .lineValid (lineValid),
      .lineDirty (lineDirty),
      .lineTag   (lineTag),
      .lineWord  (lineWord),
      .wordWe    (wordWe),
      .wrOffset  (wrOffset),
      .wrData    (wrData),
      .tagWe     (tagWe),
      .wrTag     (reqTag),
      .dirtySet  (dirtySet),
      .dirtyClr  (dirtyClr)
   );

   // Array updates: store hits in COMPARE, refill beats in ALLOCATE,
   // and the victim becomes clean once its last beat is acknowledged.
   always_comb begin
      wordWe   = 1'b0;
      wrOffset = beatCnt;
      wrData   = bus.memReadData;
      tagWe    = 1'b0;
      dirtySet = 1'b0;
      dirtyClr = 1'b0;
      case (state)
         ST_COMPARE: begin
            if (hit && !reqIsRead) begin
               wordWe   = 1'b1;
               wrOffset = reqOffset;
               wrData   = reqData;
               dirtySet = 1'b1;
            end
         end
         ST_WRITEBACK: begin
            dirtyClr = beatDone && (beatCnt == LastBeat);
         end
         ST_ALLOCATE: begin
            wordWe = beatDone;
            tagWe  = beatDone && (beatCnt == LastBeat);
         end
         default: ;
      endcase
   end

   // Sequencer. In the burst states memReq rises while low and falls on the
   // acknowledging edge, which leaves exactly one idle cycle between beats.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state            <= ST_IDLE;
         beatCnt          <= '0;
         missFlag         <= 1'b0;
         reqIsRead        <= 1'b0;
         reqAddr          <= '0;
         reqData          <= '0;
         bus.cpuReady     <= 1'b0;
         bus.readData     <= '0;
         bus.isHit        <= 1'b0;
         bus.memReq       <= 1'b0;
         bus.memWrite     <= 1'b0;
         bus.memAddress   <= '0;
         bus.memWriteData <= '0;
      end else begin
         bus.cpuReady <= 1'b0;
         bus.isHit    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.cpuReq) begin
                  reqIsRead <= bus.isRead;
                  reqAddr   <= bus.address;
                  reqData   <= bus.writeData;
                  missFlag  <= 1'b0;
                  state     <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               if (hit) begin
                  bus.cpuReady <= 1'b1;
                  bus.isHit    <= !missFlag;
                  if (reqIsRead) begin
                     bus.readData <= lineWord;
                  end
                  state <= ST_IDLE;
               end else begin
                  missFlag <= 1'b1;
                  beatCnt  <= '0;
                  state    <= (lineValid && lineDirty) ? ST_WRITEBACK : ST_ALLOCATE;
               end
            end
            ST_WRITEBACK: begin
               if (!bus.memReq) begin
                  bus.memReq       <= 1'b1;
                  bus.memWrite     <= 1'b1;
                  bus.memAddress   <= {lineTag, reqIndex, beatCnt};
                  bus.memWriteData <= lineWord;
               end else if (bus.memAck) begin
                  bus.memReq <= 1'b0;
                  beatCnt    <= beatCnt + 1'b1;
                  if (beatCnt == LastBeat) begin
                     state <= ST_ALLOCATE;
                  end
               end
            end
            ST_ALLOCATE: begin
               if (!bus.memReq) begin
                  bus.memReq     <= 1'b1;
                  bus.memWrite   <= 1'b0;
                  bus.memAddress <= {reqTag, reqIndex, beatCnt};
               end else if (bus.memAck) begin
                  bus.memReq <= 1'b0;
                  beatCnt    <= beatCnt + 1'b1;
                  if (beatCnt == LastBeat) begin
                     state <= ST_COMPARE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   // A miss is only ever seen on the first compare, since a refill always hits.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         hitCount  <= '0;
         missCount <= '0;
         wbCount   <= '0;
      end else begin
         if (state == ST_COMPARE && hit && !missFlag) begin
            hitCount <= satInc(hitCount);
         end
         if (state == ST_COMPARE && !hit) begin
            missCount <= satInc(missCount);
         end
         if (dirtyClr) begin
            wbCount <= satInc(wbCount);
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed bench for cache_ctrl_wb: a main-memory responder with adjustable
// ack delay logs every beat; expected values are hand-computed per scenario.
module tb_cache_ctrl_wb;

   logic clk = 1'b0;
   logic rstN;

   cache_ctrl_wb_if bus ();

`ifdef CACHE_STATS_EN
   logic [15:0] hitCount;
   logic [15:0] missCount;
   logic [15:0] wbCount;
`endif

   cache_ctrl_wb dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
`ifdef CACHE_STATS_EN
      ,
      .hitCount  (hitCount),
      .missCount (missCount),
      .wbCount   (wbCount)
`endif
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   logic [31:0] mem [1024];
   int          ackDelay = 1;
   int          waitCnt  = 0;
   int          cycleNum = 0;
   logic        inBeat   = 1'b0;
   int          riseCycle;
   logic [9:0]  riseAddr;
   int          unstable = 0;

   int          beatNum = 0;
   logic [9:0]  beatAddr [32];
   logic        beatWr   [32];
   logic [31:0] beatData [32];
   int          beatRise [32];
   int          beatAck  [32];

   logic [31:0] gotData;
   logic        gotHit;
   int          gotLatency;
   logic        pulseAfter;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Memory model: acts on the falling edge so the DUT sees stable ack/data.
   always @(negedge clk) begin
      cycleNum++;
      if (bus.memAck === 1'b1) begin
         bus.memAck = 1'b0;
      end else if (bus.memReq === 1'b1) begin
         if (!inBeat) begin
            inBeat    = 1'b1;
            riseCycle = cycleNum;
            riseAddr  = bus.memAddress;
            waitCnt   = 0;
         end else if (bus.memAddress !== riseAddr) begin
            unstable++;
         end
         if (waitCnt == ackDelay) begin
            bus.memAck = 1'b1;
            if (bus.memWrite) begin
               mem[bus.memAddress] = bus.memWriteData;
            end else begin
               bus.memReadData = mem[bus.memAddress];
            end
            if (beatNum < 32) begin
               beatAddr[beatNum] = bus.memAddress;
               beatWr[beatNum]   = bus.memWrite;
               beatData[beatNum] = bus.memWrite ? bus.memWriteData : mem[bus.memAddress];
               beatRise[beatNum] = riseCycle;
               beatAck[beatNum]  = cycleNum;
            end
            beatNum++;
            inBeat = 1'b0;
         end else begin
            waitCnt++;
         end
      end else begin
         bus.memAck = 1'b0;
         inBeat     = 1'b0;
         waitCnt    = 0;
      end
   end

   function automatic int countWrites();
      int n = 0;
      for (int i = 0; i < beatNum && i < 32; i++) begin
         if (beatWr[i]) n++;
      end
      return n;
   endfunction

   task automatic applyStimulus(input logic rd, input logic [9:0] addr, input logic [31:0] wdata);
      beatNum = 0;
      @(negedge clk);
      bus.cpuReq    = 1'b1;
      bus.isRead    = rd;
      bus.address   = addr;
      bus.writeData = wdata;
      @(posedge clk);
      @(negedge clk);
      bus.cpuReq = 1'b0;
      gotLatency = 1;
      while (!bus.cpuReady && gotLatency < 400) begin
         @(negedge clk);
         gotLatency++;
      end
      checkOutput("cpuReadyDone", {31'd0, bus.cpuReady}, 32'd1);
      gotData = bus.readData;
      gotHit  = bus.isHit;
      @(negedge clk);
      pulseAfter = bus.cpuReady;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[10'h000] = 32'h3cc3;
      mem[10'h200] = 32'h0ccc;
      mem[10'h300] = 32'h00c3;
      rstN          = 1'b0;
      bus.cpuReq    = 1'b0;
      bus.isRead    = 1'b0;
      bus.address   = '0;
      bus.writeData = '0;

      repeat (3) @(negedge clk);
      checkOutput("rstCpuReady", {31'd0, bus.cpuReady}, 32'd0);
      checkOutput("rstIsHit", {31'd0, bus.isHit}, 32'd0);
      checkOutput("rstReadData", bus.readData, 32'd0);
      checkOutput("rstMemReq", {31'd0, bus.memReq}, 32'd0);
      checkOutput("rstMemAddress", {22'd0, bus.memAddress}, 32'd0);
      rstN = 1'b1;

      $display("[TB] scenario 1: cold read miss of 0x000");
      applyStimulus(1'b1, 10'h000, 32'd0);
      checkOutput("s1Beats", beatNum, 32'd4);
      checkOutput("s1WriteBeats", countWrites(), 32'd0);
      for (int i = 0; i < 4; i++) checkOutput("s1BeatAddr", {22'd0, beatAddr[i]}, i);
      checkOutput("s1Data", gotData, 32'h3cc3);
      checkOutput("s1Hit", {31'd0, gotHit}, 32'd0);
      checkOutput("s1PulseEnds", {31'd0, pulseAfter}, 32'd0);

      $display("[TB] scenario 2: write hit then read hit");
      applyStimulus(1'b0, 10'h000, 32'hff);
      checkOutput("s2WrLatency", gotLatency, 32'd2);
      checkOutput("s2WrHit", {31'd0, gotHit}, 32'd1);
      checkOutput("s2WrBeats", beatNum, 32'd0);
      checkOutput("s2MemUntouched", mem[10'h000], 32'h3cc3);
      applyStimulus(1'b1, 10'h000, 32'd0);
      checkOutput("s2RdData", gotData, 32'hff);
      checkOutput("s2RdHit", {31'd0, gotHit}, 32'd1);
      checkOutput("s2RdLatency", gotLatency, 32'd2);

      $display("[TB] scenario 3: dirty victim write-back then refill");
      applyStimulus(1'b1, 10'h200, 32'd0);
      checkOutput("s3Beats", beatNum, 32'd8);
      for (int i = 0; i < 4; i++) begin
         checkOutput("s3WbAddr", {21'd0, beatWr[i], beatAddr[i]}, 32'h400 + i);
         checkOutput("s3RfAddr", {21'd0, beatWr[i+4], beatAddr[i+4]}, 32'h200 + i);
      end
      checkOutput("s3WbData0", beatData[0], 32'hff);
      checkOutput("s3Data", gotData, 32'h0ccc);
      checkOutput("s3Hit", {31'd0, gotHit}, 32'd0);
      checkOutput("s3MemWritten", mem[10'h000], 32'hff);

      $display("[TB] scenario 4: clean victims are not written back");
      applyStimulus(1'b1, 10'h300, 32'd0);
      checkOutput("s4aWriteBeats", countWrites(), 32'd0);
      checkOutput("s4aBeats", beatNum, 32'd4);
      checkOutput("s4aData", gotData, 32'h00c3);
      checkOutput("s4aHit", {31'd0, gotHit}, 32'd0);
      applyStimulus(1'b1, 10'h000, 32'd0);
      checkOutput("s4bWriteBeats", countWrites(), 32'd0);
      checkOutput("s4bData", gotData, 32'hff);
      checkOutput("s4bHit", {31'd0, gotHit}, 32'd0);

`ifdef CACHE_STATS_EN
      checkOutput("statHits", {16'd0, hitCount}, 32'd2);
      checkOutput("statMisses", {16'd0, missCount}, 32'd4);
      checkOutput("statWbs", {16'd0, wbCount}, 32'd1);
`endif

      $display("[TB] scenario 5: slow memory and reset mid write-back");
      ackDelay = 3;
      applyStimulus(1'b0, 10'h000, 32'h55);
      checkOutput("s5WrHit", {31'd0, gotHit}, 32'd1);
      unstable = 0;
      applyStimulus(1'b1, 10'h200, 32'd0);
      checkOutput("s5Beats", beatNum, 32'd8);
      for (int i = 0; i < 8; i++) begin
         checkOutput("s5ReqHeld", beatAck[i] - beatRise[i], 32'd3);
         if (i > 0) checkOutput("s5OneLowCycle", beatRise[i] - beatAck[i-1], 32'd2);
      end
      checkOutput("s5AddrStable", unstable, 32'd0);
      checkOutput("s5Data", gotData, 32'h0ccc);
      checkOutput("s5MemWb", mem[10'h000], 32'h55);

      // Write miss: refill 0x000 block, then the store lands and dirties it.
      applyStimulus(1'b0, 10'h000, 32'h77);
      checkOutput("s5WrMissHit", {31'd0, gotHit}, 32'd0);
      checkOutput("s5WrMissWbs", countWrites(), 32'd0);

      beatNum = 0;
      @(negedge clk);
      bus.cpuReq  = 1'b1;
      bus.isRead  = 1'b1;
      bus.address = 10'h300;
      @(posedge clk);
      @(negedge clk);
      bus.cpuReq = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus.memReq && bus.memWrite && bus.memAddress == 10'h001) break;
         @(negedge clk);
      end
      checkOutput("s5WbBeat1", {20'd0, bus.memReq, bus.memWrite, bus.memAddress}, 32'hc01);
      #2 rstN = 1'b0;
      #1;
      checkOutput("s5RstMemReq", {31'd0, bus.memReq}, 32'd0);
      checkOutput("s5RstMemWrite", {31'd0, bus.memWrite}, 32'd0);
      checkOutput("s5RstMemAddr", {22'd0, bus.memAddress}, 32'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      checkOutput("s5Beat0Landed", mem[10'h000], 32'h77);
`ifdef CACHE_STATS_EN
      checkOutput("statRstHits", {16'd0, hitCount}, 32'd0);
`endif
      applyStimulus(1'b1, 10'h000, 32'd0);
      checkOutput("s5PostRstHit", {31'd0, gotHit}, 32'd0);
      checkOutput("s5PostRstWbs", countWrites(), 32'd0);
      checkOutput("s5PostRstBeats", beatNum, 32'd4);
      checkOutput("s5PostRstData", gotData, 32'h77);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/cache_ctrl_wb.md
Name: cache_ctrl_wb

Overview:
Sequencing controller for the write-back, direct-mapped data cache. Accepts one CPU read or write at a time, performs tag compare, and on a miss runs victim write-back and block refill bursts to main memory over a req/ack interface. Holds the tag, valid, dirty and data arrays. Sits between the CPU-side load/store port and the main memory model.

Parameters:
ADDR_W, 10, word address width
DATA_W, 32, data word width
INDEX_W, 2, line index bits (4 lines)
OFFSET_W, 2, word-in-block bits (4 words per block); tag width = ADDR_W-INDEX_W-OFFSET_W = 6

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
cpuReq  in  1  CPU request valid; sampled only in IDLE
isRead  in  1  1=read, 0=write
address  in  ADDR_W  word address
writeData  in  DATA_W  store data
cpuReady  out  1  one-cycle completion pulse
readData  out  DATA_W  load data, valid while cpuReady=1
isHit  out  1  1 if the request hit on first compare, valid while cpuReady=1
memReq  out  1  memory beat request
memWrite  out  1  1=write beat, 0=read beat
memAddress  out  ADDR_W  beat word address
memWriteData  out  DATA_W  write beat data
memReadData  in  DATA_W  read beat data, valid with memAck
memAck  in  1  beat complete; ignored while memReq=0

Behaviour:
- Reset (rstN low, async): state IDLE, all valid/dirty cleared, beat counter 0, all outputs 0. Data/tag arrays not reset. Reset mid-burst abandons the burst; memReq drops immediately; dirty data is lost.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: on edge with cpuReq=1, latch isRead/address/writeData, clear missFlag, go COMPARE. Inputs ignored in all other states.
- COMPARE: hit = valid[idx] && tag[idx]==addrTag. Hit: read returns word; write updates word, sets dirty. At this edge register cpuReady=1, isHit=!missFlag, readData (reads only; writes leave readData unchanged), go IDLE. Hit latency: cpuReady high in the 2nd cycle after the sampling edge. CPU must drop cpuReq while cpuReady=1, otherwise the request is re-sampled as new.
- COMPARE miss: set missFlag; dirty victim -> WRITEBACK; clean or invalid -> ALLOCATE. Counter reset to 0.
- WRITEBACK: memWrite=1, memAddress={victimTag,idx,cnt}, memWriteData=data[idx][cnt]. memReq held until memAck; after each ack memReq low exactly one cycle, cnt++. After ack of beat 3: clear dirty, go ALLOCATE, cnt=0.
- ALLOCATE: memWrite=0, memAddress={addrTag,idx,cnt}, same req/ack rule; on ack write memReadData into data[idx][cnt]. After beat 3: tag=addrTag, valid=1, dirty=0, go COMPARE (now hits; isHit reports 0 via missFlag).
- Write miss is write-allocate: refill, then write in COMPARE.
- Beat counter wraps 3->0; beats always in offset order 0..3 irrespective of requested offset.
- cpuReady, isHit are 0 outside the completion cycle.

Optional Feature:
CACHE_STATS_EN: when defined, adds outputs hitCount, missCount, wbCount (16 bits each, saturating at 0xFFFF, cleared by reset). hitCount increments on completion with isHit=1, missCount on each first-compare miss, wbCount on each completed write-back burst. When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header cache_pkg: state encodings, ADDR_W/DATA_W/INDEX_W/OFFSET_W defaults, BLOCK_WORDS=4, tag-width derivation.
- One sub-module cache_line_store: valid/dirty/tag/data arrays with combinational read and synchronous word write, tag write, and dirty set/clear; valid/dirty async-cleared on rstN.

Test Plan:
- Memory preloaded mem[0x000]=0x3cc3, mem[0x200]=0xccc, mem[0x300]=0xc3; memAck one cycle after memReq. Read 0x000 after reset -> no write beats, 4 read beats at 0x000..0x003, cpuReady with readData=0x3cc3, isHit=0.
- Write 0x000 data 0xff -> cpuReady 2 cycles after sampling, isHit=1, zero memReq, mem[0x000] still 0x3cc3; then read 0x000 -> readData=0xff, isHit=1.
- Read 0x200 -> 4 write beats 0x000..0x003 (first data 0xff), then 4 read beats 0x200..0x203; readData=0xccc, isHit=0; mem[0x000]=0xff afterwards.
- Read 0x300 (line now clean) -> no write beats, readData=0xc3, isHit=0; then read 0x000 -> readData=0xff, isHit=0, no write beats.
- memAck delayed 3 cycles per beat -> memReq held high, memAddress stable until ack, one low cycle between beats; rstN pulsed low during WRITEBACK beat 1 -> memReq 0 immediately, next read 0x000 misses.
- With CACHE_STATS_EN, after scenarios 1-4 -> hitCount=2, missCount=4, wbCount=1.
